// File: rtl/count_display_driver.sv
// ---------------------------------------------------------------------------
// count_display_driver
//
// Converts the 8-bit binary press count to three BCD digits with a
// sequential double-dabble converter, then time-multiplexes the digits onto
// a common-anode 4-digit seven-segment display. The converted value and a
// one-cycle completion strobe are exported for observability.
//
// Parameters:
//   REFRESH_DIV  clock cycles each digit stays lit (2 .. 2**24)
//
// Ports:
//   clk        in   system clock
//   reset      in   synchronous, active-high reset
//   count[7:0] in   binary value to display
//   an[3:0]    out  digit anodes, active-low; an[0] = ones, an[2] = hundreds,
//                   an[3] is unused and held high
//   seg[6:0]   out  segments {g,f,e,d,c,b,a}, active-low
//   dp         out  decimal point, active-low, held off (1)
//   bcd[11:0]  out  last converted value {hundreds, tens, ones}
//   bcd_valid  out  one-cycle pulse in the cycle bcd is updated
//
// Build option:
//   LEADING_ZERO_BLANK_EN  when defined, a zero hundreds digit is blanked, and
//                          the tens digit is blanked when hundreds and tens
//                          are both zero. Slot timing is unchanged.
// ---------------------------------------------------------------------------
module count_display_driver #(
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  count,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [11:0] bcd,
    output logic        bcd_valid
);

    // Refresh counter must hold 0 .. REFRESH_DIV-1.
    localparam int unsigned CntW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CntW-1:0] RefreshLast = CntW'(REFRESH_DIV - 1);

    // -----------------------------------------------------------------------
    // Double-dabble converter
    // -----------------------------------------------------------------------
    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    state_e      state;
    logic        first;       // forces one conversion after reset
    logic [7:0]  last_count;  // value most recently taken for conversion
    logic [7:0]  shreg;       // binary bits still to be shifted in
    logic [11:0] scratch;     // BCD accumulator
    logic [2:0]  bit_cnt;     // shifts completed so far
    logic [11:0] scratch_adj;

    // Add 3 to every nibble >= 5 so the following left shift carries
    // correctly into the next decimal digit.
    function automatic logic [11:0] dabble_adjust(input logic [11:0] v);
        logic [11:0] r;
        for (int i = 0; i < 3; i++) begin
            r[i*4 +: 4] = (v[i*4 +: 4] >= 4'd5) ? v[i*4 +: 4] + 4'd3 : v[i*4 +: 4];
        end
        return r;
    endfunction

    always_comb begin
        scratch_adj = dabble_adjust(scratch);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= StIdle;
            first      <= 1'b1;
            last_count <= 8'd0;
            shreg      <= 8'd0;
            scratch    <= 12'd0;
            bit_cnt    <= 3'd0;
            bcd        <= 12'd0;
            bcd_valid  <= 1'b0;
        end else begin
            bcd_valid <= 1'b0;
            unique case (state)
                StIdle: begin
                    // Changes seen while busy are caught here via the compare.
                    if (first || (count != last_count)) begin
                        last_count <= count;
                        shreg      <= count;
                        scratch    <= 12'd0;
                        bit_cnt    <= 3'd0;
                        first      <= 1'b0;
                        state      <= StShift;
                    end
                end
                StShift: begin
                    scratch <= {scratch_adj[10:0], shreg[7]};
                    shreg   <= {shreg[6:0], 1'b0};
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        state <= StDone;
                    end
                end
                StDone: begin
                    bcd       <= scratch;
                    bcd_valid <= 1'b1;
                    state     <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Digit scan timing
    // -----------------------------------------------------------------------
    logic [CntW-1:0] refresh_cnt;
    logic [1:0]      digit_idx;

    always_ff @(posedge clk) begin
        if (reset) begin
            refresh_cnt <= '0;
            digit_idx   <= 2'd0;
        end else if (refresh_cnt == RefreshLast) begin
            refresh_cnt <= '0;
            digit_idx   <= (digit_idx == 2'd2) ? 2'd0 : digit_idx + 2'd1;
        end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Segment decode and registered display outputs
    // -----------------------------------------------------------------------
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    logic [3:0] sel_nib;
    logic       blank;
    logic [3:0] an_next;
    logic [6:0] seg_next;

    always_comb begin
        sel_nib = 4'd0;
        an_next = 4'b1111;
        unique case (digit_idx)
            2'd0: begin
                sel_nib = bcd[3:0];
                an_next = 4'b1110;
            end
            2'd1: begin
                sel_nib = bcd[7:4];
                an_next = 4'b1101;
            end
            2'd2: begin
                sel_nib = bcd[11:8];
                an_next = 4'b1011;
            end
            default: begin
                sel_nib = 4'd0;
                an_next = 4'b1111;
            end
        endcase

`ifdef LEADING_ZERO_BLANK_EN
        // Ones digit is never blanked so a zero count still shows "0".
        blank = ((digit_idx == 2'd2) && (bcd[11:8] == 4'd0)) ||
                ((digit_idx == 2'd1) && (bcd[11:4] == 8'd0));
`else
        blank = 1'b0;
`endif

        if (blank) begin
            an_next  = 4'b1111;
            seg_next = 7'b1111111;
        end else begin
            seg_next = seg_decode(sel_nib);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            an  <= 4'b1111;
            seg <= 7'b1111111;
        end else begin
            an  <= an_next;
            seg <= seg_next;
        end
    end

    assign dp = 1'b1;

endmodule

// File: tb/tb_count_display_driver.sv
module tb_count_display_driver;

    localparam int unsigned DIV = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  count = 8'd0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic [11:0] bcd;
    logic        bcd_valid;

    always #5 clk = ~clk;

    count_display_driver #(
        .REFRESH_DIV(DIV)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .count    (count),
        .an       (an),
        .seg      (seg),
        .dp       (dp),
        .bcd      (bcd),
        .bcd_valid(bcd_valid)
    );

    typedef struct {
        logic [11:0] val;
        int          due;
    } exp_t;

    exp_t exp_q[$];   // scoreboard: expected completions, popped by the monitor
    exp_t pend_q[$];  // same events, consumed by the display model

    int checks = 0;
    int errors = 0;

    // Reference model state
    int          k;         // edges since reset release
    bit          m_first;
    logic [7:0]  m_last;
    int          free_k;    // earliest edge a new sample may be taken
    logic [11:0] m_bcd;
    logic [3:0]  exp_an;
    logic [6:0]  exp_seg;

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        case (n)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d, t=%0t)", name, act, exp, k, $time);
        end
    endtask

    // Model: evaluated at each rising edge from the inputs the DUT samples.
    initial begin
        int         d;
        logic [3:0] nib;
        logic [3:0] onehot;
        bit         blank;
        exp_t       e;
        forever begin
            @(posedge clk);
            if (reset) begin
                k       = 0;
                m_first = 1'b1;
                m_last  = 8'd0;
                free_k  = 1;
                m_bcd   = 12'd0;
                exp_q.delete();
                pend_q.delete();
                exp_an  = 4'b1111;
                exp_seg = 7'b1111111;
            end else begin
                k++;
                // Digit shown after this edge uses the digit/bcd held before it.
                d      = ((k - 1) / DIV) % 3;
                nib    = m_bcd[d*4 +: 4];
                blank  = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
                if (d == 2 && m_bcd[11:8] == 4'd0) blank = 1'b1;
                if (d == 1 && m_bcd[11:4] == 8'd0) blank = 1'b1;
`endif
                onehot  = 4'b0001 << d;
                exp_an  = blank ? 4'b1111 : ~onehot;
                exp_seg = blank ? 7'b1111111 : seg_of(nib);
                if (pend_q.size() > 0 && pend_q[0].due == k) begin
                    m_bcd = pend_q[0].val;
                    void'(pend_q.pop_front());
                end
                if (k >= free_k && (m_first || count != m_last)) begin
                    m_last  = count;
                    m_first = 1'b0;
                    e.val   = to_bcd(int'(count));
                    e.due   = k + 9;
                    exp_q.push_back(e);
                    pend_q.push_back(e);
                    free_k  = k + 10;
                end
            end
        end
    end

    // Monitor: compares outputs shortly after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            check("an", int'(an), int'(exp_an));
            check("seg", int'(seg), int'(exp_seg));
            check("dp", int'(dp), 1);
            check("bcd_hold", int'(bcd), int'(m_bcd));
            if (bcd_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_bcd_valid", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("bcd_value", int'(bcd), int'(e.val));
                    check("bcd_latency", k, e.due);
                end
            end else if (exp_q.size() > 0 && exp_q[0].due <= k) begin
                e = exp_q.pop_front();
                check("missing_bcd_valid", 0, 1);
            end
        end
    end

    // Stimulus
    initial begin
        reset = 1'b1;
        count = 8'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (15) @(negedge clk);

        count = 8'd255;
        repeat (40) @(negedge clk);

        count = 8'd7;
        repeat (3) @(negedge clk);
        count = 8'd200;
        repeat (30) @(negedge clk);

        // Reset in the middle of a conversion
        count = 8'd100;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (30) @(negedge clk);

        count = 8'd5;
        repeat (40) @(negedge clk);

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 2) != 0) count = 8'($urandom);
            if ($urandom_range(0, 79) == 0) begin
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
            end
            repeat ($urandom_range(1, 14)) @(negedge clk);
        end

        repeat (30) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
